// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I fetch-path constants and response record
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
    logic err;
  } rsp_t;
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request / instruction response handshake bundle
interface imem_responder_if;
  import rv32i_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [XLEN-1:0] req_addr;
  logic rsp_valid;
  logic rsp_ready;
  logic [XLEN-1:0] rsp_inst;
  logic [XLEN-1:0] rsp_addr;
  logic rsp_err;
  modport master(
    output req_valid, req_addr, rsp_ready,
    input req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );
  modport slave(
    input req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder_rsp_fifo.sv
// rsp_fifo: in-order response buffer with synchronous clear
module rsp_fifo
  import rv32i_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  rsp_t wdata,
  output rsp_t rdata,
  output logic full,
  output logic empty
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  rsp_t mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign full = cnt == CW'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // an empty buffer presents an all-zero record so idle outputs read as zero
  assign rdata = empty ? '0 : mem[rp];
  // pointers and occupancy; clear drops everything including a same-cycle push
  always_ff @(posedge clk)
    if (reset || clear) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop) rp <= inc(rp);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  // storage needs no reset, occupancy decides what is visible
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory with in-order response buffer
module imem_responder
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  imem_responder_if.slave bus,
  input logic flush,
  input logic load_en,
  input logic [XLEN-1:0] load_addr,
  input logic [XLEN-1:0] load_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  logic [XLEN-1:0] mem [DEPTH] = '{default: NOP_INST};
  logic acc, req_err, load_ok, push_v, pop, full, empty;
  logic [AW-1:0] widx;
  logic [OW-1:0] outstanding;
  rsp_t req_d, push_d, head;
  assign load_ok = load_en && (load_addr >> AW) == '0;
  assign widx = bus.req_addr[AW+1:2];
  assign req_err = bus.req_addr[1:0] != 2'b00 || (bus.req_addr >> (AW + 2)) != '0;
  assign bus.req_ready = !reset && !flush && outstanding < OW'(FIFO_DEPTH);
  assign acc = bus.req_valid && bus.req_ready;
  assign req_d = '{
    inst: req_err ? NOP_INST : (load_ok && load_addr[AW-1:0] == widx) ? load_data : mem[widx],
    addr: bus.req_addr,
    err: req_err
  };
  // program image load, independent of fetch traffic and flush
  always_ff @(posedge clk)
    if (load_ok) mem[load_addr[AW-1:0]] <= load_data;
  if (LATENCY == 1) begin : g_direct
    assign push_v = acc;
    assign push_d = req_d;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv;
    rsp_t pd [LATENCY-1];
    // delay line; the buffer write supplies the final cycle of latency
    always_ff @(posedge clk) begin
      pv <= (reset || flush) ? '0 : (LATENCY - 1)'({pv, acc});
      pd[0] <= req_d;
      for (int i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
    end
    assign push_v = pv[LATENCY-2];
    assign push_d = pd[LATENCY-2];
  end
  assign pop = !empty && bus.rsp_ready;
  // in-flight count across delay line and buffer bounds buffer occupancy
  always_ff @(posedge clk)
    outstanding <= (reset || flush) ? '0 : outstanding + OW'(acc) - OW'(pop);
  rsp_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push_v),
    .pop(pop),
    .clear(flush),
    .wdata(push_d),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign bus.rsp_valid = !empty;
  assign bus.rsp_inst = head.inst;
  assign bus.rsp_addr = head.addr;
  assign bus.rsp_err = head.err;
  a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush) !(push_v && full));
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed scenario checks for imem_responder
module tb_imem_responder;
  import rv32i_pkg::*;
  localparam logic [31:0] W0 = 32'h00500093;
  localparam logic [31:0] W1 = 32'h00A00113;
  localparam logic [31:0] W2 = 32'h00F00193;
  localparam logic [31:0] W3 = 32'h01400213;
  localparam logic [31:0] WL = 32'h12345678;
  logic clk = 1'b0;
  logic reset, flush, load_en;
  logic [31:0] load_addr, load_data;
  int errors = 0;
  int checks = 0;
  imem_responder_if bus();
  imem_responder #(.DEPTH(1024), .LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .flush(flush),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );
  always #5 clk = ~clk;

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [65:0] got;
    reset = 1'b1;
    flush = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
    end
    got = {bus.rsp_valid, bus.rsp_inst, bus.rsp_addr, bus.rsp_err};
    checks++;
    if (got !== 66'h0) begin
      errors++;
      $display("FAIL reset_rsp: got %h want 0", got);
    end
    checks++;
    if (dut.outstanding !== 3'd0) begin
      errors++;
      $display("FAIL reset_outstanding: got %0d want 0", dut.outstanding);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_req_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_basic;
    logic [65:0] got, exp;
    do_load(32'd0, W0);
    do_load(32'd1, W1);
    do_load(32'd2, W2);
    do_load(32'd3, W3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      bus.req_valid = c < 2;
      bus.req_addr = 32'(4 * c);
      #1;
      got = {bus.rsp_valid, bus.rsp_inst, bus.rsp_addr, bus.rsp_err};
      exp = c == 2 ? {1'b1, W0, 32'h0, 1'b0} : c == 3 ? {1'b1, W1, 32'h4, 1'b0} : 66'h0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_cycle%0d: got %h want %h", c, got, exp);
      end
    end
  endtask

  task automatic test_back_pressure;
    logic [65:0] got, exp;
    logic [31:0] w [4];
    w = '{W0, W1, W2, W3};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr = 32'(4 * c);
      #1;
      checks++;
      if (bus.req_ready !== (c < 4)) begin
        errors++;
        $display("FAIL bp_ready_cycle%0d: got %b want %b", c, bus.req_ready, c < 4);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;
      if (k == 0) begin
        checks++;
        if (bus.req_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_full_ready: got %b want 0", bus.req_ready);
        end
      end
      got = {bus.rsp_valid, bus.rsp_inst, bus.rsp_addr, bus.rsp_err};
      exp = {1'b1, w[k], 32'(4 * k), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bp_rsp%0d: got %h want %h", k, got, exp);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_drain: got valid/ready %b want 01", {bus.rsp_valid, bus.req_ready});
    end
  endtask

  task automatic test_flush;
    logic [65:0] got, exp;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr = 32'(4 * c);
    end
    @(negedge clk);
    flush = 1'b1;
    bus.req_addr = 32'h8;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_ready: got %b want 0", bus.req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready, dut.outstanding} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL flush_after: got valid=%b ready=%b outstanding=%0d want 0 1 0",
               bus.rsp_valid, bus.req_ready, dut.outstanding);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.req_valid = c == 0;
      bus.req_addr = 32'h8;
      #1;
      got = {bus.rsp_valid, bus.rsp_inst, bus.rsp_addr, bus.rsp_err};
      exp = c == 2 ? {1'b1, W2, 32'h8, 1'b0} : 66'h0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL flush_cycle%0d: got %h want %h", c, got, exp);
      end
    end
  endtask

  task automatic test_errors;
    logic [65:0] got, exp [6];
    logic [31:0] a [3];
    a = '{32'h00001000, 32'h00000002, 32'h00000FFC};
    exp = '{66'h0, 66'h0, {1'b1, NOP_INST, 32'h00001000, 1'b1},
            {1'b1, NOP_INST, 32'h00000002, 1'b1}, {1'b1, WL, 32'h00000FFC, 1'b0}, 66'h0};
    do_load(32'd1023, WL);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      bus.req_valid = c < 3;
      bus.req_addr = c < 3 ? a[c] : 32'h0;
      #1;
      got = {bus.rsp_valid, bus.rsp_inst, bus.rsp_addr, bus.rsp_err};
      checks++;
      if (got !== exp[c]) begin
        errors++;
        $display("FAIL err_cycle%0d: got %h want %h", c, got, exp[c]);
      end
    end
  endtask

  task automatic test_collision;
    logic [65:0] got, exp;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      bus.req_valid = c == 0;
      bus.req_addr = 32'hC;
      load_en = c < 2;
      load_addr = c == 0 ? 32'd3 : 32'd1024;
      load_data = c == 0 ? 32'hDEADBEEF : 32'hBAD0BAD0;
      #1;
      got = {bus.rsp_valid, bus.rsp_inst, bus.rsp_addr, bus.rsp_err};
      exp = c == 2 ? {1'b1, 32'hDEADBEEF, 32'hC, 1'b0} : 66'h0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL collide_cycle%0d: got %h want %h", c, got, exp);
      end
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [65:0] got, exp;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr = 32'(4 * c);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, dut.outstanding} !== {1'b0, 3'd3}) begin
      errors++;
      $display("FAIL rst_mid_before: got ready=%b outstanding=%0d want 0 3", bus.req_ready, dut.outstanding);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, dut.outstanding} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL rst_mid_after: got valid=%b outstanding=%0d want 0 0", bus.rsp_valid, dut.outstanding);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus.req_valid = c == 3;
      bus.req_addr = 32'h0;
      #1;
      got = {bus.rsp_valid, bus.rsp_inst, bus.rsp_addr, bus.rsp_err};
      exp = c == 5 ? {1'b1, W0, 32'h0, 1'b0} : 66'h0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rst_mid_cycle%0d: got %h want %h", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_flush();
    test_errors();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
